// File: rtl/dds_sweep_controller.sv
// dds_sweep_controller: frequency-sweep sequencer for the DDS phase accumulator.
// Latches a start/stop/step/dwell configuration over a valid/ready handshake.
// Drives the accumulator frequency word, enable and clear, and counts
// carry-outs (quarter periods) to step the frequency after each dwell.
// Optional feature macro: SWEEP_WRAP_EN. When it is defined, the sweep restarts
// from the start word instead of finishing in DONE.
module dds_sweep_controller #(
    parameter int unsigned FW_WIDTH    = 8,
    parameter int unsigned DWELL_WIDTH = 8
) (
    input  logic                   clk_star,
    input  logic                   reset_n,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [FW_WIDTH-1:0]    cfg_start,
    input  logic [FW_WIDTH-1:0]    cfg_stop,
    input  logic [FW_WIDTH-1:0]    cfg_step,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic                   go,
    input  logic                   abort,
    input  logic                   co,
    output logic [FW_WIDTH-1:0]    freq_word,
    output logic                   acc_en,
    output logic                   acc_clr,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned SUM_WIDTH = FW_WIDTH + 1;
    localparam int unsigned Q_WIDTH   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 state;
    logic [FW_WIDTH-1:0]    start_r;
    logic [FW_WIDTH-1:0]    stop_r;
    logic [FW_WIDTH-1:0]    step_r;
    logic [DWELL_WIDTH-1:0] dwell_r;
    logic [Q_WIDTH-1:0]     q;
    logic [DWELL_WIDTH-1:0] p;

    logic                   cfg_fire_c;
    logic [DWELL_WIDTH-1:0] dwell_last_c;
    logic [SUM_WIDTH-1:0]   sum_c;
    logic                   period_done_c;
    logic                   last_dwell_c;
    logic                   sweep_end_c;

    // Config is only accepted while no sweep is in progress
    assign cfg_ready  = (state == IDLE) || (state == DONE);
    assign cfg_fire_c = cfg_valid && cfg_ready;

    // Last period index of a dwell; a dwell of 0 behaves as 1
    assign dwell_last_c = (dwell_r == '0) ? '0 : DWELL_WIDTH'(dwell_r - 1'b1);

    // Next word computed one bit wider so an overflow past stop is never missed
    assign sum_c = SUM_WIDTH'(freq_word) + SUM_WIDTH'(step_r);

    // Period and sweep boundary decode for the RUN state
    assign period_done_c = co && (q == Q_WIDTH'(3));
    assign last_dwell_c  = (p == dwell_last_c);
    assign sweep_end_c   = (step_r == '0) || (sum_c > SUM_WIDTH'(stop_r));

    // Sweep sequencer: state, counters, latched config and registered outputs
    always_ff @(posedge clk_star or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            start_r   <= '0;
            stop_r    <= '0;
            step_r    <= '0;
            dwell_r   <= DWELL_WIDTH'(1);
            q         <= '0;
            p         <= '0;
            freq_word <= '0;
            acc_en    <= 1'b0;
            acc_clr   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            acc_clr <= 1'b0;
            done    <= 1'b0;

            if (cfg_fire_c) begin
                start_r <= cfg_start;
                stop_r  <= cfg_stop;
                step_r  <= cfg_step;
                dwell_r <= cfg_dwell;
            end

            if (abort) begin
                state  <= IDLE;
                acc_en <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (go) begin
                            state     <= ARM;
                            freq_word <= cfg_fire_c ? cfg_start : start_r;
                            q         <= '0;
                            p         <= '0;
                            acc_clr   <= 1'b1;
                            acc_en    <= 1'b0;
                            busy      <= 1'b1;
                        end
                    end
                    ARM: begin
                        state  <= RUN;
                        acc_en <= 1'b1;
                    end
                    RUN: begin
                        if (co) begin
                            q <= Q_WIDTH'(q + 1'b1);
                        end
                        if (period_done_c) begin
                            if (!last_dwell_c) begin
                                p <= DWELL_WIDTH'(p + 1'b1);
                            end else if (!sweep_end_c) begin
                                freq_word <= sum_c[FW_WIDTH-1:0];
                                p         <= '0;
                            end else begin
                                done <= 1'b1;
`ifdef SWEEP_WRAP_EN
                                freq_word <= start_r;
                                p         <= '0;
                                q         <= '0;
                                acc_clr   <= 1'b1;
`else
                                state  <= DONE;
                                acc_en <= 1'b0;
                                busy   <= 1'b0;
`endif
                            end
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        acc_en <= 1'b0;
                        busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/dds_sweep_controller.md
# dds_sweep_controller

Sequencer for the phase-accumulator / quadrant-controller datapath of the sine generator. It loads a frequency sweep configuration (start, stop, step, dwell) over a valid/ready handshake, then drives the accumulator's frequency word, enable and clear. It counts accumulator carry-outs to measure completed output periods, and advances the frequency word after each dwell. It sits between the lab's control inputs (switches/buttons) and the accumulator.

## Interface
- FW_WIDTH, 8, width of frequency word and config start/stop/step
- DWELL_WIDTH, 8, width of dwell count (full output periods per frequency)

- clk_star  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- cfg_valid  in  1  config offer
- cfg_ready  out  1  config accepted when cfg_valid & cfg_ready at a clock edge
- cfg_start / cfg_stop / cfg_step  in  FW_WIDTH  sweep first word, upper bound, increment
- cfg_dwell  in  DWELL_WIDTH  periods per step; 0 treated as 1
- go  in  1  start sweep (level sampled)
- abort  in  1  cancel sweep
- co  in  1  accumulator carry-out, one pulse per quarter period
- freq_word  out  FW_WIDTH  accumulator increment
- acc_en  out  1  accumulator enable
- acc_clr  out  1  one-cycle accumulator/quadrant clear
- busy  out  1  high in ARM and RUN
- done  out  1  one-cycle pulse at sweep end

## Operation
- States: IDLE, ARM, RUN, DONE. Reset state IDLE.
- cfg_ready = 1 in IDLE and DONE, 0 otherwise. Accepted config is latched into internal registers. Reset values: start/stop/step 0, dwell 1.
- IDLE/DONE + go -> ARM. If cfg handshake and go occur in the same cycle, the new config is used.
- ARM (1 cycle): acc_clr=1, freq_word<=start, quadrant counter q<=0, period counter p<=0 -> RUN.
- RUN: acc_en=1. Each co increments q mod 4. co with q==3 completes a period.
- On period completion with p==dwell-1 (dwell 0 counts as 1):
  - end condition: step==0, or freq_word+step > stop (computed FW_WIDTH+1 bits, no wrap).
  - not end: freq_word<=freq_word+step, p<=0.
  - end: see Configuration.
- On period completion with p<dwell-1: p<=p+1.
- start>stop: one dwell at start, then end.
- abort (any state, priority over co and go) -> IDLE next cycle. acc_en=0, freq_word held, no done pulse.
- DONE: acc_en=0, freq_word holds the last word, go re-arms.
- co is ignored outside RUN.

## Timing
- Reset values: freq_word 0, acc_en 0, acc_clr 0, busy 0, done 0, cfg_ready 1.
- All outputs except cfg_ready are registered. cfg_ready is decoded from state.
- go sampled at edge N: ARM during cycle N+1 (acc_clr=1, busy=1, freq_word=start). RUN from N+2 (acc_en=1).
- A completing co sampled at edge M: new freq_word visible from M+1. The done pulse and acc_en=0 also take effect from M+1.
- reset_n low mid-sweep: all state and outputs return to reset values immediately. Latched config is also reset.

## Configuration
- SWEEP_WRAP_EN defined: at end condition, freq_word<=start, p<=0, q<=0, and acc_clr pulses for one cycle. The block stays in RUN, busy stays 1, and done pulses once per completed sweep. Only abort or reset leaves RUN.
- Not defined: at end condition -> DONE, done pulses one cycle, acc_en=0.

## Test plan
- Reset: assert reset_n=0 mid-RUN -> freq_word 0, acc_en 0, busy 0, done 0, cfg_ready 1. After release, state is IDLE.
- Basic sweep: start=10, stop=30, step=10, dwell=2, then go.
  - acc_clr pulse, then freq_word=10.
  - After 8 co -> 20; after 16 co -> 30.
  - After 24 co -> done pulse, acc_en 0, freq_word 30.
- Abort: basic config, abort after 5 co -> IDLE next cycle, busy 0, no done. Further co pulses leave freq_word unchanged.
- Degenerate: start=50, stop=20, step=5, dwell=0 -> 4 co then done, freq_word 50. Repeat with step=0, start=stop=20 -> done after 4 co.
- Handshake: cfg_valid during RUN -> cfg_ready 0, config unchanged. cfg_valid+go in the same IDLE cycle with start=7 -> freq_word 7 in ARM.
- With SWEEP_WRAP_EN, basic sweep: after 24 co -> freq_word 10, acc_clr pulse, done pulse, busy stays 1. After 48 co -> second done pulse.
